// File: rtl/potato_pipe_if.sv
// potato_pipe_if: valid/ready bus for potato_pipe, carrying the input word
// (with its per-word op) and the output word with their handshakes.
// The slave modport is the pipe's own view; master is the producer/consumer view.
interface potato_pipe_if #(
    parameter int WIDTH = 32
);
    logic             i_rdy;
    logic             i_val;
    logic [WIDTH-1:0] i_data;
    logic [1:0]       i_op;
    logic             o_rdy;
    logic             o_val;
    logic [WIDTH-1:0] o_data;

    modport slave (
        output i_rdy,
        input  i_val,
        input  i_data,
        input  i_op,
        input  o_rdy,
        output o_val,
        output o_data
    );

    modport master (
        input  i_rdy,
        output i_val,
        output i_data,
        output i_op,
        output o_rdy,
        input  o_val,
        input  o_data
    );
endinterface

// File: rtl/potato_pipe.sv
// potato_pipe: DEPTH-stage valid/ready register pipe with bubble collapsing.
// The last stage applies a per-word op (pass, +STEP, -STEP, invert).
// The pipe also provides a registered occupancy count and a synchronous flush.
// Optional feature macro: POTATO_PIPE_STATS_EN builds the 32-bit in/out transfer
// counters. When the macro is undefined, in_cnt and out_cnt read 0.
module potato_pipe #(
    parameter int          WIDTH = 32,
    parameter int          DEPTH = 2,
    parameter logic [63:0] STEP  = 64'd1,
    parameter int          OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    potato_pipe_if.slave     bus,
    input  logic             flush,
    output logic [OCC_W-1:0] occ,
    output logic [31:0]      in_cnt,
    output logic [31:0]      out_cnt
);

    localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];

    logic [DEPTH-1:0] val;
    logic [DEPTH-1:0] val_nxt;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] data [DEPTH];
    logic [1:0]       op   [DEPTH-1];
    logic [WIDTH-1:0] op_result;
    logic             rdy_chain;
    logic             in_fire;
    logic             out_fire;

    assign bus.i_rdy  = rdy[0] && !flush;
    assign bus.o_val  = val[DEPTH-1];
    assign bus.o_data = data[DEPTH-1];
    assign in_fire    = bus.i_val && bus.i_rdy;
    assign out_fire   = val[DEPTH-1] && bus.o_rdy;

    // Ready ripples backwards: a stage can take a word if it is empty or anything downstream frees up
    always_comb begin
        rdy       = '0;
        rdy_chain = bus.o_rdy || !val[DEPTH-1];
        rdy[DEPTH-1] = rdy_chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            rdy_chain = rdy_chain || !val[k];
            rdy[k]    = rdy_chain;
        end
    end

    // A stage loads when its upstream has a word and it is ready to take it
    always_comb begin
        load    = '0;
        load[0] = in_fire;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = val[k-1] && rdy[k];
        end
    end

    // Valid bits: set on load, cleared when the word leaves without a refill, all cleared by flush
    always_comb begin
        val_nxt = val;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (load[k]) begin
                val_nxt[k] = 1'b1;
            end else if (load[k+1]) begin
                val_nxt[k] = 1'b0;
            end
        end
        if (load[DEPTH-1]) begin
            val_nxt[DEPTH-1] = 1'b1;
        end else if (bus.o_rdy) begin
            val_nxt[DEPTH-1] = 1'b0;
        end
        if (flush) begin
            val_nxt = '0;
        end
    end

    // Output-stage operation applied to the word arriving from the second-to-last stage
    always_comb begin
        op_result = data[DEPTH-2];
        case (op[DEPTH-2])
            2'b00:   op_result = data[DEPTH-2];
            2'b01:   op_result = data[DEPTH-2] + STEP_W;
            2'b10:   op_result = data[DEPTH-2] - STEP_W;
            default: op_result = ~data[DEPTH-2];
        endcase
    end

    // Stage registers: data and op move unchanged until the output stage, which stores the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
            for (int k = 0; k < DEPTH - 1; k++) begin
                op[k] <= 2'b00;
            end
        end else begin
            val <= val_nxt;
            if (load[0]) begin
                data[0] <= bus.i_data;
                op[0]   <= bus.i_op;
            end
            for (int k = 1; k < DEPTH - 1; k++) begin
                if (load[k]) begin
                    data[k] <= data[k-1];
                    op[k]   <= op[k-1];
                end
            end
            if (load[DEPTH-1]) begin
                data[DEPTH-1] <= op_result;
            end
        end
    end

    // Occupancy tracks accepted minus delivered words; flush empties the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (in_fire && !out_fire) begin
            occ <= occ + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ <= occ - OCC_W'(1);
        end
    end

`ifdef POTATO_PIPE_STATS_EN
    // Free-running transfer counters, untouched by flush, wrap modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_fire) begin
                in_cnt <= in_cnt + 32'd1;
            end
            if (out_fire) begin
                out_cnt <= out_cnt + 32'd1;
            end
        end
    end
`else
    assign in_cnt  = '0;
    assign out_cnt = '0;
`endif

endmodule
